// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and constants for the convolution window
//                sequencers (FSM states, kernel sizes, index width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Sequencer control states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TAP      = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Supported kernel sizes
    localparam logic [2:0] K3 = 3'd3;
    localparam logic [2:0] K5 = 3'd5;
    localparam logic [2:0] K7 = 3'd7;

    // Largest kernel and its tap count (tap_idx must cover MAX_TAPS-1)
    localparam int KMAX_SUPPORTED = 7;
    localparam int MAX_TAPS       = KMAX_SUPPORTED * KMAX_SUPPORTED;

    // Signed width able to hold any row/column index of the image
    function automatic int idx_width(input int rows, input int cols);
        int m;
        m = (rows > cols) ? rows : cols;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_tap_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_tap_addr_gen
//  Description : Combinational tap generator. For output pixel (r, c),
//                channel ch and kernel offset (dy, dx) of a KxK kernel,
//                produces the source byte address, the out-of-image flag
//                and the coefficient index dy*K+dx.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_tap_addr_gen #(
    parameter int ROWS   = 192,
    parameter int COLS   = 192,
    parameter int CH     = 3,
    parameter int ADDR_W = 17,
    parameter int IW     = 9,
    parameter int CHW    = 2
) (
    input  logic [IW-1:0]     r,
    input  logic [IW-1:0]     c,
    input  logic [CHW-1:0]    ch,
    input  logic [2:0]        dy,
    input  logic [2:0]        dx,
    input  logic [2:0]        k,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              tap_pad,
    output logic [5:0]        tap_idx
);

    // Tap coordinates need headroom beyond the index width: a small image
    // with a large kernel reaches K/2 rows past either edge.
    localparam int TW = IW + 4;

    localparam logic signed [TW-1:0] c_rows   = TW'(ROWS);
    localparam logic signed [TW-1:0] c_cols   = TW'(COLS);
    localparam logic [ADDR_W-1:0]    c_cols_a = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0]    c_ch_a   = ADDR_W'(CH);

    logic signed [TW-1:0] w_half;
    logic signed [TW-1:0] w_tr;
    logic signed [TW-1:0] w_tc;
    logic [ADDR_W-1:0]    w_row_u;
    logic [ADDR_W-1:0]    w_col_u;

    // Signed tap position, edge test, then unsigned address of in-image taps
    always_comb begin
        w_half   = $signed(TW'(k[2:1]));
        w_tr     = $signed(TW'(r)) + $signed(TW'(dy)) - w_half;
        w_tc     = $signed(TW'(c)) + $signed(TW'(dx)) - w_half;
        tap_pad  = w_tr[TW-1] || (w_tr >= c_rows) || w_tc[TW-1] || (w_tc >= c_cols);
        w_row_u  = ADDR_W'(w_tr);
        w_col_u  = ADDR_W'(w_tc);
        tap_addr = tap_pad ? '0 : ((w_row_u * c_cols_a + w_col_u) * c_ch_a + ADDR_W'(ch));
        tap_idx  = 6'(dy) * 6'(k) + 6'(dx);
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_sequencer
//  Description : Walks every output pixel/channel of a pixel-interleaved
//                image, issues the KxK kernel taps of each window to a shared
//                MAC datapath, waits for its result and issues the write.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int ROWS   = 192,
    parameter int COLS   = 192,
    parameter int CH     = 3,
    parameter int ADDR_W = 17,
    parameter int KMAX   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        ksize,
    output logic              busy,
    output logic              done,
    output logic              err_ksize,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              tap_pad,
    output logic [5:0]        tap_idx,
    output logic              tap_first,
    output logic              tap_last,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int IW  = idx_width(ROWS, COLS);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [IW-1:0]     c_last_row = IW'(ROWS - 1);
    localparam logic [IW-1:0]     c_last_col = IW'(COLS - 1);
    localparam logic [CHW-1:0]    c_last_ch  = CHW'(CH - 1);
    localparam logic [ADDR_W-1:0] c_cols_a   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_ch_a     = ADDR_W'(CH);

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_row;
    logic [IW-1:0]     r_col;
    logic [CHW-1:0]    r_ch;
    logic [2:0]        r_dy;
    logic [2:0]        r_dx;
    logic [2:0]        r_k;
    logic              r_err;

    logic              w_ksize_ok;
    logic              w_tap_fire;
    logic              w_tap_last;
    logic              w_last_pixel;
    logic [ADDR_W-1:0] w_gen_addr;
    logic              w_gen_pad;
    logic [5:0]        w_gen_idx;
    logic [ADDR_W-1:0] w_pix_addr;

    assign w_ksize_ok   = ((ksize == K3) || (ksize == K5) || (ksize == K7)) && (int'(ksize) <= KMAX);
    assign w_tap_fire   = (r_state == ST_TAP) && tap_ready;
    assign w_tap_last   = (r_dy == r_k - 3'd1) && (r_dx == r_k - 3'd1);
    assign w_last_pixel = (r_row == c_last_row) && (r_col == c_last_col) && (r_ch == c_last_ch);
    assign w_pix_addr   = (ADDR_W'(r_row) * c_cols_a + ADDR_W'(r_col)) * c_ch_a + ADDR_W'(r_ch);
    assign err_ksize    = r_err;

    conv_tap_addr_gen #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .CH     (CH),
        .ADDR_W (ADDR_W),
        .IW     (IW),
        .CHW    (CHW)
    ) u_tap_gen (
        .r        (r_row),
        .c        (r_col),
        .ch       (r_ch),
        .dy       (r_dy),
        .dx       (r_dx),
        .k        (r_k),
        .tap_addr (w_gen_addr),
        .tap_pad  (w_gen_pad),
        .tap_idx  (w_gen_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (start && w_ksize_ok) w_next = ST_TAP;
            ST_TAP:      if (w_tap_fire && w_tap_last) w_next = ST_WAIT_RES;
            ST_WAIT_RES: if (res_valid) w_next = ST_WRITE;
            ST_WRITE:    if (wr_ready) w_next = w_last_pixel ? ST_DONE : ST_TAP;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; tap/write fields are zero unless valid
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        tap_valid = 1'b0;
        tap_addr  = '0;
        tap_pad   = 1'b0;
        tap_idx   = '0;
        tap_first = 1'b0;
        tap_last  = 1'b0;
        res_ready = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        case (r_state)
            ST_TAP: begin
                busy      = 1'b1;
                tap_valid = 1'b1;
                tap_addr  = w_gen_addr;
                tap_pad   = w_gen_pad;
                tap_idx   = w_gen_idx;
                tap_first = (r_dy == 3'd0) && (r_dx == 3'd0);
                tap_last  = w_tap_last;
            end
            ST_WAIT_RES: begin
                busy      = 1'b1;
                res_ready = 1'b1;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                wr_valid  = 1'b1;
                wr_addr   = w_pix_addr;
            end
            ST_DONE: begin
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Loop counters: (dy, dx) advance per accepted tap, (r, c, ch) per accepted write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_ch  <= '0;
            r_dy  <= '0;
            r_dx  <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_ksize_ok) begin
                        r_k   <= ksize;
                        r_row <= '0;
                        r_col <= '0;
                        r_ch  <= '0;
                        r_dy  <= '0;
                        r_dx  <= '0;
                    end
                end
                ST_TAP: begin
                    if (w_tap_fire) begin
                        if (w_tap_last) begin
                            r_dy <= '0;
                            r_dx <= '0;
                        end else if (r_dx == r_k - 3'd1) begin
                            r_dx <= '0;
                            r_dy <= r_dy + 3'd1;
                        end else begin
                            r_dx <= r_dx + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (r_ch == c_last_ch) begin
                            r_ch <= '0;
                            if (r_col == c_last_col) begin
                                r_col <= '0;
                                r_row <= (r_row == c_last_row) ? '0 : r_row + IW'(1);
                            end else begin
                                r_col <= r_col + IW'(1);
                            end
                        end else begin
                            r_ch <= r_ch + CHW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky kernel-size error, re-evaluated on every start seen in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err <= !w_ksize_ok;
        end
    end

endmodule
`default_nettype wire
